// File: rtl/ps2_key_injector.sv
// rtl/ps2_key_injector.sv - queues scancode bytes and replays them as device-to-host PS/2 frames
// Outputs feed the core's keyboard inputs directly, so both lines come straight from flops.
module ps2_key_injector #(
  parameter int CLK_DIV    = 350,
  parameter int GAP_CYCLES = 1400,
  parameter int FIFO_AW    = 3
) (
  input  logic               sys_clock,
  input  logic               reset_n,
  input  logic [7:0]         din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               ps2_clk,
  output logic               ps2_din,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    DIV_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         head;
  logic               push;
  logic               pop;
  logic               fifo_nonempty;

  logic [CW-1:0]      cnt;
  logic [3:0]         bitcnt;
  logic [10:0]        frame;
  logic               cnt_zero;
  logic               bit_last;

  logic               load_frame;
  logic               clk_fall;
  logic               clk_rise_next;
  logic               clk_rise_stop;
  logic               cnt_dec;

  // ---------------------------------------------------------------- FIFO
  assign fifo_nonempty = (count != '0);
  assign din_ready     = (count < DEPTH_C);
  assign push          = din_valid && din_ready;
  assign pop           = load_frame;
  assign head          = mem[rd_ptr];
  assign fifo_count    = count;

  always_ff @(posedge sys_clock) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- frame FSM
  assign cnt_zero = (cnt == '0);
  assign bit_last = (bitcnt == 4'd10);
  assign busy     = (state != IDLE) || fifo_nonempty;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fifo_nonempty) state_nxt = HIGH;
      HIGH: if (cnt_zero)      state_nxt = LOW;
      LOW:  if (cnt_zero)      state_nxt = bit_last ? GAP : HIGH;
      GAP:  if (cnt_zero)      state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_frame    = 1'b0;
    clk_fall      = 1'b0;
    clk_rise_next = 1'b0;
    clk_rise_stop = 1'b0;
    cnt_dec       = 1'b0;
    case (state)
      IDLE: load_frame = fifo_nonempty;
      HIGH: begin
        clk_fall = cnt_zero;
        cnt_dec  = !cnt_zero;
      end
      LOW: begin
        clk_rise_next = cnt_zero && !bit_last;
        clk_rise_stop = cnt_zero && bit_last;
        cnt_dec       = !cnt_zero;
      end
      GAP:     cnt_dec = !cnt_zero;
      default: cnt_dec = 1'b0;
    endcase
  end

  // frame is a shift register: bit 0 always holds the bit currently on the wire
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      ps2_clk <= 1'b1;
      ps2_din <= 1'b1;
      cnt     <= '0;
      bitcnt  <= '0;
      frame   <= '1;
    end else if (load_frame) begin
      frame   <= {1'b1, ~^head, head, 1'b0};
      bitcnt  <= '0;
      ps2_din <= 1'b0;
      cnt     <= DIV_LOAD;
    end else if (clk_fall) begin
      ps2_clk <= 1'b0;
      cnt     <= DIV_LOAD;
    end else if (clk_rise_next) begin
      ps2_clk <= 1'b1;
      ps2_din <= frame[1];
      frame   <= {1'b1, frame[10:1]};
      bitcnt  <= bitcnt + 1'b1;
      cnt     <= DIV_LOAD;
    end else if (clk_rise_stop) begin
      ps2_clk <= 1'b1;
      ps2_din <= 1'b1;
      cnt     <= GAP_LOAD;
    end else if (cnt_dec) begin
      cnt     <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_injector.sv
// tb/tb_ps2_key_injector.sv - directed bench decoding PS/2 frames off the injector outputs
module tb_ps2_key_injector;

  localparam int DIV   = 8;
  localparam int GAP   = 12;
  localparam int AW    = 3;
  localparam int FLEN  = 22 * DIV;
  localparam int PER   = FLEN + GAP + 1;

  logic          sys_clock = 1'b0;
  logic          reset_n   = 1'b0;
  logic [7:0]    din       = 8'h00;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          ps2_clk;
  logic          ps2_din;
  logic          busy;
  logic [AW:0]   fifo_count;

  int total = 0;
  int bad   = 0;

  ps2_key_injector #(.CLK_DIV(DIV), .GAP_CYCLES(GAP), .FIFO_AW(AW)) dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ps2_clk    (ps2_clk),
    .ps2_din    (ps2_din),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 sys_clock = ~sys_clock;

  int cyc = 0;
  always @(posedge sys_clock) cyc <= cyc + 1;

  // receiver: samples data on each falling ps2_clk, frame closes on the following rise
  int          nbits = 0;
  int          falls = 0;
  logic        p_clk = 1'b1;
  logic        p_din = 1'b1;
  logic [10:0] sh;
  int          start_q[$];
  int          fall_q[$];
  int          rise_q[$];
  logic [10:0] frame_q[$];

  always @(negedge sys_clock) begin
    if (!reset_n) begin
      nbits = 0;
      p_clk = 1'b1;
      p_din = 1'b1;
    end else begin
      if (nbits == 0 && p_din && !ps2_din && ps2_clk) start_q.push_back(cyc);
      if (p_clk && !ps2_clk) begin
        if (nbits < 11) sh[nbits] = ps2_din;
        if (nbits == 0) fall_q.push_back(cyc);
        nbits++;
        falls++;
      end
      if (!p_clk && ps2_clk && nbits == 11) begin
        rise_q.push_back(cyc);
        frame_q.push_back(sh);
        nbits = 0;
      end
      p_clk = ps2_clk;
      p_din = ps2_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic par);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic push1(input logic [7:0] b);
    @(negedge sys_clock);
    din       = b;
    din_valid = 1'b1;
    @(negedge sys_clock);
    din_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frame_q.size() < n && k < budget) begin
      @(negedge sys_clock);
      k++;
    end
    chk(tag, frame_q.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge sys_clock);
      k++;
    end
    chk(tag, busy, 1'b0);
  endtask

  int   base;
  int   busy_cyc;
  int   falls_snap;
  int   starts_snap;
  int   frames_snap;
  logic [7:0] seq [8];

  initial begin
    // reset state
    repeat (3) @(negedge sys_clock);
    chk("rst_clk", ps2_clk, 1'b1);
    chk("rst_din", ps2_din, 1'b1);
    chk("rst_ready", din_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge sys_clock);

    // single byte 0x1C: parity 0, timing from the pop edge
    push1(8'h1C);
    wait_frames(1, PER + 20, "single_done");
    chk("single_frame", frame_q[0], mkframe(8'h1C, 1'b0));
    chk("single_first_fall", fall_q[0] - start_q[0], DIV);
    chk("single_end_rise", rise_q[0] - start_q[0], FLEN);
    wait_idle(GAP + 20, "single_idle");
    busy_cyc = cyc;
    chk("single_busy_drop", busy_cyc - start_q[0], FLEN + GAP);
    chk("single_lines_idle", {ps2_clk, ps2_din}, 2'b11);

    // 0x00 then 0xF0 on consecutive cycles; second push coincides with the pop
    base = frame_q.size();
    @(negedge sys_clock);
    din = 8'h00; din_valid = 1'b1;
    @(negedge sys_clock);
    chk("pp_count_after_push", fifo_count, 1);
    din = 8'hF0;
    @(negedge sys_clock);
    din_valid = 1'b0;
    chk("pp_count_simul", fifo_count, 1);
    chk("pp_busy", busy, 1'b1);
    wait_frames(base + 2, 2 * PER + 40, "par_done");
    chk("par_frame0", frame_q[base], mkframe(8'h00, 1'b1));
    chk("par_frame1", frame_q[base + 1], mkframe(8'hF0, 1'b1));
    chk("par_spacing", start_q[base + 1] - start_q[base], PER);
    wait_idle(PER, "par_idle");

    // fill the FIFO while a frame is in flight
    base = frame_q.size();
    push1(8'h5A);
    @(negedge sys_clock);
    chk("full_popped", fifo_count, 0);
    for (int i = 0; i < 8; i++) begin
      seq[i]    = 8'(8'h11 * (i + 1));
      din       = seq[i];
      din_valid = 1'b1;
      @(negedge sys_clock);
    end
    din = 8'h99;
    chk("full_ready_low", din_ready, 1'b0);
    chk("full_count8", fifo_count, 8);
    @(negedge sys_clock);
    chk("full_count_hold", fifo_count, 8);
    din_valid = 1'b0;
    wait_frames(base + 9, 10 * PER, "full_done");
    wait_idle(2 * PER, "full_idle");
    repeat (PER) @(negedge sys_clock);
    chk("full_nframes", frame_q.size() - base, 9);
    chk("full_first", frame_q[base], mkframe(8'h5A, 1'b1));
    for (int i = 0; i < 8; i++)
      chk($sformatf("full_order%0d", i), frame_q[base + 1 + i], mkframe(seq[i], ~^seq[i]));

    // loopback-style sequence: make/break of key A
    base = frame_q.size();
    @(negedge sys_clock);
    din = 8'h1C; din_valid = 1'b1;
    @(negedge sys_clock);
    din = 8'hF0;
    @(negedge sys_clock);
    din = 8'h1C;
    @(negedge sys_clock);
    din_valid = 1'b0;
    wait_frames(base + 3, 4 * PER, "seq_done");
    chk("seq_make", frame_q[base], mkframe(8'h1C, 1'b0));
    chk("seq_break_pfx", frame_q[base + 1], mkframe(8'hF0, 1'b1));
    chk("seq_break_key", frame_q[base + 2], mkframe(8'h1C, 1'b0));
    wait_idle(2 * PER, "seq_idle");

    // reset during bit 5 with another byte still queued
    push1(8'h3C);
    push1(8'h7E);
    begin
      int k = 0;
      while (nbits < 6 && k < PER) begin
        @(negedge sys_clock);
        k++;
      end
      chk("rst_reach_bit5", nbits >= 6, 1);
    end
    frames_snap = frame_q.size();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_clk", ps2_clk, 1'b1);
    chk("mid_rst_din", ps2_din, 1'b1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 1'b0);
    repeat (3) @(negedge sys_clock);
    reset_n = 1'b1;
    falls_snap  = falls;
    starts_snap = start_q.size();
    repeat (3 * PER) @(negedge sys_clock);
    chk("post_rst_falls", falls, falls_snap);
    chk("post_rst_starts", start_q.size(), starts_snap);
    chk("post_rst_frames", frame_q.size(), frames_snap);
    chk("post_rst_lines", {ps2_clk, ps2_din}, 2'b11);

    push1(8'h29);
    wait_frames(frames_snap + 1, PER + 20, "recover_done");
    chk("recover_frame", frame_q[frames_snap], mkframe(8'h29, ~^8'h29));
    wait_idle(PER, "recover_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_injector.md
Name: ps2_key_injector

Overview:
- Upstream stage of the keyboard path: accepts PS/2 set-2 scancode bytes from a host-side source (OSD paste, autotype or test loader) and serializes them as device-to-host PS/2 frames on ps2_clk/ps2_din.
- Its outputs drive the core's ps2_clk/ps2_din inputs directly, with no extra glue.
- Contains an input FIFO, a half-period timing counter and a frame FSM.

Parameters:
- CLK_DIV, 350, sys_clock cycles per PS/2 clock half-period (≥2).
- GAP_CYCLES, 1400, idle sys_clock cycles after each frame's stop bit (≥1).
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW.

Ports:
- sys_clock  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- din  in  8  scancode byte to send.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  FIFO can accept a byte.
- ps2_clk  out  1  generated PS/2 clock, idle high.
- ps2_din  out  1  generated PS/2 data, idle high.
- busy  out  1  high while the FSM is not in IDLE or the FIFO is non-empty.
- fifo_count  out  FIFO_AW+1  bytes currently queued.

Behaviour:
- Interface: one clock (sys_clock); reset is asynchronous and active-low (reset_n).
- Reset values: ps2_clk=1, ps2_din=1, din_ready=1, busy=0, fifo_count=0. The FIFO is emptied and the FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame immediately. The lines return high asynchronously, and no partial frame resumes after release.
- FIFO push: occurs when din_valid && din_ready. din_ready = (fifo_count < 2**FIFO_AW), registered-count based.
- Valid while full: valid with ready low is ignored; the byte is dropped, and holding it is the upstream's job.
- Simultaneous push and pop in one cycle leaves fifo_count unchanged.
- Frame: 11 bits sent in order: start 0, data[0..7] LSB first, odd parity (~^data), stop 1.
- FSM states: IDLE, HIGH, LOW, GAP. Counter cnt is a half-period/gap down-counter; bitcnt is 0..10.
- IDLE:
  - If fifo_count≠0, pop the head byte.
  - Next edge: frame ← {1, ~^byte, byte, 0}, bitcnt←0, ps2_din←0, cnt←CLK_DIV-1, state←HIGH.
  - If the FIFO is empty, stay in IDLE with both lines high.
- HIGH: ps2_clk=1. When cnt==0: ps2_clk←0, cnt←CLK_DIV-1, state←LOW. Otherwise cnt--.
- LOW: ps2_clk=0. When cnt==0: ps2_clk←1, then:
  - If bitcnt==10: ps2_din←1, cnt←GAP_CYCLES-1, state←GAP.
  - Else: bitcnt++, ps2_din←frame[bitcnt+1], cnt←CLK_DIV-1, state←HIGH.
  - Otherwise cnt--.
- GAP: both lines high. When cnt==0, state←IDLE; otherwise cnt--.
- Data timing: ps2_din changes only on the edge where ps2_clk rises (or, for the start bit, on frame entry). It is therefore stable for a full half-period before every falling edge, where the receiver samples.
- Timing: the first falling edge of ps2_clk occurs CLK_DIV cycles after the pop edge.
  - One frame occupies 22·CLK_DIV cycles, plus GAP_CYCLES before the next pop can occur.
  - Back-to-back queued bytes are separated by exactly GAP_CYCLES+1 cycles of idle-high lines.
- Exactly 11 falling edges per frame; never a glitch or runt pulse on ps2_clk. Both outputs come directly from flops.
- Byte boundaries: multi-byte sequences (E0 xx, F0 xx) are simply consecutive FIFO entries; no interpretation of codes.

Test Plan:
- Single byte: reset, push 0x1C once.
  - Decode 11 bits at ps2_clk falling edges → 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
  - First fall 350 cycles after pop; ps2_clk returns high 7700 cycles after pop; busy drops after the 1400-cycle gap.
- Parity: push 0x00 then 0xF0.
  - Expect parity bits 1 and 1.
  - Second frame's start bit appears 7700+1400+1 cycles after the first pop.
- FIFO full: with the FSM stalled mid-frame, push 9 bytes continuously.
  - 8 are accepted; din_ready=0 with fifo_count=8 on the 9th.
  - Exactly 8 further frames are emitted, in order.
- Simultaneous push/pop: push on the same cycle IDLE pops.
  - fifo_count holds its value; both bytes are transmitted in order.
- Reset mid-frame: assert reset_n=0 during bit 5.
  - ps2_clk=ps2_din=1 immediately, fifo_count=0.
  - After release, no edges occur until a new push.
- Receiver loopback: connect to the core's keyboard decoder and push 1C F0 1C.
  - The decoder reports exactly one key 'A' make and one break; no framing or parity errors.
